// File: rtl/uart_rx_buffer.sv
// Byte FIFO between the UART receiver and the memory loaders; replays bytes as single-cycle pulses.
// Optional running XOR checksum of accepted bytes is built only when UART_RX_CHECKSUM_EN is defined.
module uart_rx_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] in_byte,
    input  logic                  in_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_byte,
    output logic                  out_valid,
    output logic [CNT_W-1:0]      count,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic [DATA_WIDTH-1:0] checksum
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wrPtrReg;
    logic [PTR_W-1:0]      rdPtrReg;
    logic [CNT_W-1:0]      countReg;
    logic                  overflowReg;

    logic doPop;
    logic doPush;
    logic doDrop;

    // Decisions use the count held before the edge, so a byte never pops on the edge that stores it.
    assign empty  = (countReg == '0);
    assign full   = (countReg == CNT_W'(DEPTH));
    assign doPop  = out_ready && !empty;
    assign doPush = in_valid && (!full || doPop);
    assign doDrop = in_valid && full && !doPop;

    assign count    = countReg;
    assign overflow = overflowReg;

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (rstN && !flush && doPush) begin
            mem[wrPtrReg] <= in_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            wrPtrReg    <= '0;
            rdPtrReg    <= '0;
            countReg    <= '0;
            overflowReg <= 1'b0;
            out_byte    <= '0;
            out_valid   <= 1'b0;
        end else if (flush) begin
            wrPtrReg    <= '0;
            rdPtrReg    <= '0;
            countReg    <= '0;
            overflowReg <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            out_valid <= doPop;
            if (doPop) begin
                out_byte <= mem[rdPtrReg];
                rdPtrReg <= rdPtrReg + PTR_W'(1);
            end
            if (doPush) begin
                wrPtrReg <= wrPtrReg + PTR_W'(1);
            end
            if (doPush && !doPop) begin
                countReg <= countReg + CNT_W'(1);
            end else if (doPop && !doPush) begin
                countReg <= countReg - CNT_W'(1);
            end
            if (doDrop) begin
                overflowReg <= 1'b1;
            end
        end
    end

`ifdef UART_RX_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksumReg;

    always_ff @(posedge clk) begin
        if (!rstN || flush) begin
            checksumReg <= '0;
        end else if (doPush) begin
            checksumReg <= checksumReg ^ in_byte;
        end
    end

    assign checksum = checksumReg;
`else
    assign checksum = '0;
`endif

endmodule

// File: doc/uart_rx_buffer.md
# uart_rx_buffer

Byte FIFO between the UART receiver in `uart_system` and the memory communication interfaces (instruction and data memory loaders). It captures every `rx_new_byte_indicate` pulse with its byte, even when the downstream loader is busy writing memory. It replays the bytes in order as single-cycle valid pulses whenever the consumer is ready. Overflow is reported, and an optional running XOR checksum of accepted bytes is provided.

## Interface
- `DATA_WIDTH`, default 8: byte width; matches `UART_WIDTH`.
- `DEPTH`, default 16: FIFO entries; must be a power of two, ≥2.
- `CNT_W`, derived `$clog2(DEPTH)+1`: width of `count`.
- `clk`  in  1  system clock (50 MHz).
- `rstN`  in  1  reset; synchronous, active-low.
- `flush`  in  1  synchronous clear of contents, overflow and checksum.
- `in_byte`  in  DATA_WIDTH  received byte; valid only with `in_valid`.
- `in_valid`  in  1  one-cycle pulse per received byte.
- `out_ready`  in  1  level: consumer can accept one byte this cycle.
- `out_byte`  out  DATA_WIDTH  registered output byte; holds its last value between pulses.
- `out_valid`  out  1  one-cycle pulse; `out_byte` is valid in the same cycle.
- `count`  out  CNT_W  number of stored entries, 0..DEPTH.
- `empty`  out  1  `count == 0`.
- `full`  out  1  `count == DEPTH`.
- `overflow`  out  1  sticky; a byte was dropped.
- `checksum`  out  DATA_WIDTH  XOR of accepted bytes (see Configuration).

## Operation
- Storage is a circular buffer with read and write pointers of `$clog2(DEPTH)` bits. Pointers wrap naturally from DEPTH-1 to 0.
- **Push:**
  - Occurs at the edge where `in_valid=1` and the FIFO is not full.
  - Also occurs when the FIFO is full and a pop happens at the same edge.
  - On push, `in_byte` is written at the write pointer and the write pointer increments.
- **Pop:**
  - Occurs at the edge where `out_ready=1` and `count != 0`, with `count` taken before that edge.
  - A byte pushed at edge N cannot be popped at edge N.
  - On pop: `out_byte` ← mem[rd_ptr], `out_valid` ← 1, and the read pointer increments.
  - Otherwise `out_valid` ← 0.
- **Simultaneous push and pop:** `count` is unchanged. This is legal at any fill level.
- **Dropped byte:** when `in_valid=1`, the FIFO is full and there is no pop, the byte is dropped, `overflow` ← 1, and the contents are unchanged.
- **Flush:**
  - Pointers ← 0, `count` ← 0, `out_valid` ← 0, `overflow` ← 0, `checksum` ← 0.
  - Flush overrides any push or pop at the same edge.
  - `out_byte` keeps its value.
- **Reset values** (`rstN=0` at an edge):
  - `out_byte`=0, `out_valid`=0, `count`=0, `empty`=1, `full`=0, `overflow`=0, `checksum`=0.
  - Memory contents are don't-care.
- **Reset mid-operation:** all stored bytes are discarded. No `out_valid` pulse is issued in the cycle after reset.
- `empty` and `full` are decoded from the registered `count`; there is no extra lag.

## Timing
- All state updates on the posedge of `clk`; no combinational path from inputs to outputs.
- Latency with the FIFO empty and `out_ready` held high:
  - `in_valid` sampled at edge N.
  - `count`=1 after edge N.
  - Pop at edge N+1; `out_valid` high in the cycle following edge N+1.
  - Total: 2 clocks.
- Throughput: one pop per cycle while `out_ready` stays high and data is available. Back-to-back `out_valid` pulses are allowed.
- The consumer must sample `out_byte` in the cycle `out_valid` is high.
- `count` reflects pushes and pops one cycle after the edge at which they occur.

## Configuration
- Macro: `UART_RX_CHECKSUM_EN`.
- **Defined:**
  - At each accepted push, `checksum` ← `checksum ^ in_byte`.
  - Dropped bytes are excluded.
  - Cleared by reset and by `flush`.
  - The host compares it against the XOR of the bytes it sent.
- **Undefined:** the `checksum` port remains and is tied to all zeros; no checksum register is built.

## Test plan
1. **Reset and single byte:** after reset, push 0xA5 with `out_ready=1`. Expect `out_valid` for exactly one cycle, 2 clocks after the push, with `out_byte`=0xA5, then `count`=0 and `empty`=1.
2. **Ordering and wrap:** hold `out_ready=0` and push 0x00..0x0F (DEPTH=16). Expect `full`=1 and `count`=16. Raise `out_ready` and expect 16 back-to-back pulses carrying 0x00..0x0F in order. Repeat twice to exercise pointer wrap.
3. **Overflow:** with the FIFO full and `out_ready=0`, push 0xFF. Expect `overflow`=1, `count`=16, and 0xFF never output. Then `flush`: expect `overflow`=0, `count`=0, and no `out_valid` pulse.
4. **Push and pop at full:** with the FIFO full, drive `in_valid`=1 (0x77) and `out_ready`=1 in the same cycle. Expect the oldest byte on `out_byte`, `count` to stay 16, `overflow` to stay 0, and 0x77 to be output last.
5. **Reset and flush priority:** assert `rstN=0` while 5 bytes are stored and `in_valid`=1 and `out_ready`=1. Expect the outputs at their reset values next cycle, and no stale bytes output afterwards. Repeat with `flush` and expect the same.
6. **Checksum:** with `UART_RX_CHECKSUM_EN` defined, push 0x12, 0x34, 0x56 and expect `checksum`=0x70. Push one more byte that is dropped on overflow and expect `checksum` unchanged. Without the macro, expect `checksum`=0x00 throughout.
